// File: rtl/vlc_pkg.sv
// Types and constants shared by the
// exp-Golomb encoder and decoder.
package vlc_pkg;

  localparam int LEN_W = 6;
  localparam int K_W   = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SUFFIX = 2'd1,
    SIGN   = 2'd2,
    DONE   = 2'd3
  } vlc_state_e;

endpackage

// File: rtl/exp_golomb_decode.sv
// Serial exp-Golomb(k) decoder, one bit
// per accepted beat, MSB first.
module exp_golomb_decode
  import vlc_pkg::*;
#(
  parameter int VAL_W = 32,
  parameter int MAX_Q = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K_W-1:0]   k,
  input  logic             is_ac_level,
  output logic [VAL_W-1:0] out_val,
  output logic             out_minus,
  output logic [LEN_W-1:0] out_len,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  vlc_state_e       state_q, state_d;
  logic [4:0]       zcnt_q, zcnt_d;
  logic [4:0]       rem_q, rem_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [K_W-1:0]   kl_q, kl_d;
  logic             acl_q, acl_d;
  logic             cfg_q, cfg_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic             minus_q, minus_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;

  logic             beat;
  logic             go_done;
  logic             sgn;
  logic [K_W-1:0]   k_eff;
  logic             ac_eff;

  assign in_ready  = (state_q != DONE);
  assign beat      = in_valid & in_ready;
  assign out_val   = val_q;
  assign out_minus = minus_q;
  assign out_len   = len_q;
  assign out_err   = err_q;
  assign out_valid = valid_q;

  // Next-state, datapath and result computation
  always_comb begin
    state_d = state_q;
    zcnt_d  = zcnt_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    kl_d    = kl_q;
    acl_d   = acl_q;
    cfg_d   = cfg_q;
    val_d   = val_q;
    minus_d = minus_q;
    len_d   = len_q;
    err_d   = err_q;
    valid_d = valid_q;
    go_done = 1'b0;
    sgn     = 1'b0;
    k_eff   = cfg_q ? kl_q : k;
    ac_eff  = cfg_q ? acl_q : is_ac_level;
    unique case (state_q)
      HUNT: begin
        if (beat) begin
          cfg_d = 1'b1;
          kl_d  = k_eff;
          acl_d = ac_eff;
          if (!in_bit) begin
            zcnt_d = zcnt_q + 5'd1;
            if (zcnt_q == 5'(MAX_Q)) begin
              state_d = DONE;
              err_d   = 1'b1;
              val_d   = '0;
              minus_d = 1'b0;
              len_d   = LEN_W'(MAX_Q + 1);
              valid_d = 1'b1;
            end
          end else begin
            acc_d = VAL_W'(1);
            rem_d = zcnt_q + 5'(k_eff);
            if (rem_d == 5'd0) begin
              if (ac_eff) state_d = SIGN;
              else        go_done = 1'b1;
            end else begin
              state_d = SUFFIX;
            end
          end
        end
      end
      SUFFIX: begin
        if (beat) begin
          acc_d = {acc_q[VAL_W-2:0], in_bit};
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            if (acl_q) state_d = SIGN;
            else       go_done = 1'b1;
          end
        end
      end
      SIGN: begin
        if (beat) begin
          sgn     = in_bit;
          go_done = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = HUNT;
          valid_d = 1'b0;
          zcnt_d  = '0;
          rem_d   = '0;
          acc_d   = '0;
          cfg_d   = 1'b0;
        end
      end
      default: state_d = HUNT;
    endcase
    if (go_done) begin
      state_d = DONE;
      valid_d = 1'b1;
      err_d   = 1'b0;
      minus_d = acl_d & sgn;
      val_d   = acc_d - (VAL_W'(1) << kl_d);
      len_d   = (LEN_W'(zcnt_d) << 1)
              + LEN_W'(kl_d)
              + LEN_W'(acl_d)
              + LEN_W'(1);
    end
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= HUNT;
      zcnt_q  <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      kl_q    <= '0;
      acl_q   <= 1'b0;
      cfg_q   <= 1'b0;
      val_q   <= '0;
      minus_q <= 1'b0;
      len_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      kl_q    <= kl_d;
      acl_q   <= acl_d;
      cfg_q   <= cfg_d;
      val_q   <= val_d;
      minus_q <= minus_d;
      len_q   <= len_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_exp_golomb_decode.sv
// Directed and model-driven checks for
// the exp-Golomb decoder.
module tb_exp_golomb_decode;
  import vlc_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic [K_W-1:0]   k;
  logic             is_ac_level;
  logic [31:0]      out_val;
  logic             out_minus;
  logic [LEN_W-1:0] out_len;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  int n_chk = 0;
  int n_fail = 0;
  bit gaps = 1'b0;

  exp_golomb_decode #(
    .VAL_W(32),
    .MAX_Q(15)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .k          (k),
    .is_ac_level(is_ac_level),
    .out_val    (out_val),
    .out_minus  (out_minus),
    .out_len    (out_len),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic send_bit(input logic b, output bit ok);
    int t;
    ok = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_bit   = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (in_ready) begin
      @(posedge clk);
      #1;
      ok = 1'b1;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic send_str(input string name, input string s);
    bit ok;
    bit all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      send_bit(s[i] == 8'h31, ok);
      if (!ok) all_ok = 1'b0;
    end
    n_chk++;
    if (!all_ok) begin
      n_fail++;
      $display("FAIL %s send: not all %0d bits accepted", name, s.len());
    end
  endtask

  task automatic check_res(input string name, input logic [31:0] ev,
                           input logic em, input int el, input logic ee);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_chk++;
    if (out_valid !== 1'b1 || out_val !== ev || out_minus !== em ||
        out_len !== LEN_W'(el) || out_err !== ee) begin
      n_fail++;
      $display("FAIL %s: got v=%0b val=%0d m=%0b len=%0d err=%0b, want v=1 val=%0d m=%0b len=%0d err=%0b",
               name, out_valid, out_val, out_minus, out_len, out_err, ev, em, el, ee);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: got out_valid=%0b in_ready=%0b, want 0/1",
               name, out_valid, in_ready);
    end
  endtask

  function automatic void encode(input int unsigned v, input int kk,
                                 input bit ac, input bit m,
                                 output string s, output int len);
    logic [31:0] x;
    int n;
    int q;
    x = v + (32'd1 << kk);
    n = 0;
    while (n < 32 && (x >> n) != 0) n++;
    q = n - 1 - kk;
    s = "";
    for (int i = 0; i < q; i++) s = {s, "0"};
    for (int i = n - 1; i >= 0; i--) s = {s, x[i] ? "1" : "0"};
    if (ac) s = {s, m ? "1" : "0"};
    len = 2 * q + kk + 1 + int'(ac);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (out_valid !== 0 || out_val !== 0 || out_len !== 0 ||
        out_minus !== 0 || out_err !== 0 || in_ready !== 1) begin
      n_fail++;
      $display("FAIL reset: got v=%0b val=%0d len=%0d m=%0b err=%0b rdy=%0b, want 0/0/0/0/0/1",
               out_valid, out_val, out_len, out_minus, out_err, in_ready);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    k = 3'd0;
    is_ac_level = 1'b0;
    send_str("k0_1", "1");
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: out_valid=%0b one cycle after beat, want 1", out_valid);
    end
    check_res("k0_1", 32'd0, 1'b0, 1, 1'b0);
    send_str("k0_00100", "00100");
    check_res("k0_00100", 32'd3, 1'b0, 5, 1'b0);
  endtask

  task automatic test_k_change();
    bit ok;
    k = 3'd2;
    is_ac_level = 1'b0;
    send_bit(1'b0, ok);
    k = 3'd0;
    is_ac_level = 1'b1;
    send_str("k2_mid", "1001");
    check_res("k2_01001", 32'd5, 1'b0, 5, 1'b0);
    is_ac_level = 1'b0;
  endtask

  task automatic test_ac_sign();
    k = 3'd0;
    is_ac_level = 1'b1;
    send_str("ac_0111", "0111");
    check_res("ac_0111", 32'd2, 1'b1, 4, 1'b0);
    is_ac_level = 1'b0;
  endtask

  task automatic test_error();
    k = 3'd0;
    is_ac_level = 1'b0;
    send_str("err_16z", "0000000000000000");
    in_valid = 1'b1;
    in_bit   = 1'b0;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL err_17th: in_ready=%0b, want 0", in_ready);
    end
    in_valid = 1'b0;
    check_res("err_16z", 32'd0, 1'b0, 16, 1'b1);
  endtask

  task automatic test_hold();
    logic [31:0] v0;
    k = 3'd1;
    is_ac_level = 1'b0;
    send_str("hold", "0110");
    v0 = out_val;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_val !== 32'd4 || out_val !== v0 || out_len !== 6'd4) begin
        n_fail++;
        $display("FAIL hold%0d: rdy=%0b v=%0b val=%0d len=%0d, want 0/1/4/4",
                 i, in_ready, out_valid, out_val, out_len);
      end
    end
    check_res("hold", 32'd4, 1'b0, 4, 1'b0);
  endtask

  task automatic test_gaps();
    gaps = 1'b1;
    k = 3'd0;
    is_ac_level = 1'b0;
    send_str("gap_00100", "00100");
    check_res("gap_00100", 32'd3, 1'b0, 5, 1'b0);
    k = 3'd2;
    send_str("gap_01001", "01001");
    check_res("gap_01001", 32'd5, 1'b0, 5, 1'b0);
    gaps = 1'b0;
  endtask

  task automatic test_mid_reset();
    k = 3'd0;
    is_ac_level = 1'b0;
    send_str("mr_00", "00");
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (out_valid !== 0 || out_val !== 0 || out_len !== 0 ||
        out_err !== 0 || in_ready !== 1) begin
      n_fail++;
      $display("FAIL mid_reset: v=%0b val=%0d len=%0d err=%0b rdy=%0b, want 0/0/0/0/1",
               out_valid, out_val, out_len, out_err, in_ready);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_str("mr_1", "1");
    check_res("mr_1", 32'd0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    string s;
    int len;
    int unsigned v;
    int kk;
    bit ac;
    bit m;
    bit ok;
    bit early;
    for (int n = 0; n < 24; n++) begin
      v  = $urandom_range(0, 4000);
      kk = $urandom_range(0, 7);
      ac = 1'($urandom_range(0, 1));
      m  = ac ? 1'($urandom_range(0, 1)) : 1'b0;
      gaps = 1'($urandom_range(0, 1));
      encode(v, kk, ac, m, s, len);
      k = 3'(kk);
      is_ac_level = ac;
      early = 1'b0;
      for (int i = 0; i < s.len(); i++) begin
        send_bit(s[i] == 8'h31, ok);
        if (!ok) early = 1'b1;
        if (i < s.len() - 1 && out_valid) early = 1'b1;
      end
      n_chk++;
      if (early) begin
        n_fail++;
        $display("FAIL b2b%0d beats: stall or early result in %0d-bit word, want none",
                 n, s.len());
      end
      check_res("b2b", v, m, len, 1'b0);
    end
    gaps = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    in_bit      = 1'b0;
    in_valid    = 1'b0;
    k           = '0;
    is_ac_level = 1'b0;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_k_change();
    test_ac_sign();
    test_error();
    test_hold();
    test_gaps();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
